fetch_buffer_unit: RTL and testbench

FETCH_BUFFER_UNIT -- requirements
Module: fetch_buffer_unit

---
 rtl/fetch_buffer_unit_pkg.sv | 10 +
 rtl/fetch_buffer_unit_fifo2.sv | 44 ++++
 rtl/fetch_buffer_unit.sv | 108 ++++++++++
 tb/tb_fetch_buffer_unit.sv | 172 +++++++++++++++++
 4 files changed

// File: rtl/fetch_buffer_unit_pkg.sv
// Shared fetch-stage definitions: FSM encoding and instruction word width.
package fetch_buffer_unit_pkg;
  localparam int INST_W = 32;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2
  } fetch_state_e;
endpackage

// File: rtl/fetch_buffer_unit_fifo2.sv
// Two-entry synchronous FIFO with flush; head is read straight from storage.
module fifo2_sync #(
  parameter int W = 32
) (
  input  logic         clock,
  input  logic         reset,
  input  logic         flush,
  input  logic         push,
  input  logic [W-1:0] push_data,
  input  logic         pop,
  output logic [W-1:0] head,
  output logic [1:0]   count
);
  logic [1:0][W-1:0] mem;
  logic              rd_ptr;
  logic              wr_ptr;
  logic              do_push;
  logic              do_pop;

  assign do_pop  = pop & (count != 2'd0);
  // A full FIFO still accepts a push when the head leaves in the same cycle.
  assign do_push = push & ((count != 2'd2) | do_pop);
  assign head    = mem[rd_ptr];

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      mem    <= '0;
      rd_ptr <= 1'b0;
      wr_ptr <= 1'b0;
      count  <= 2'd0;
    end else if (flush) begin
      rd_ptr <= 1'b0;
      wr_ptr <= 1'b0;
      count  <= 2'd0;
    end else begin
      if (do_push) begin
        mem[wr_ptr] <= push_data;
        wr_ptr      <= ~wr_ptr;
      end
      if (do_pop) rd_ptr <= ~rd_ptr;
      count <= count + {1'b0, do_push} - {1'b0, do_pop};
    end
  end
endmodule

// File: rtl/fetch_buffer_unit.sv
// Instruction fetch front end: issues sequential fetches, buffers up to two
// instructions for decode, and drops stale responses after a redirect.
module fetch_buffer_unit
  import fetch_buffer_unit_pkg::*;
#(
  parameter int                    CORE         = 0,
  parameter int                    ADDRESS_BITS = 32,
  parameter logic [ADDRESS_BITS-1:0] RESET_PC   = '0
) (
  input  logic                    clock,
  input  logic                    reset,
  output logic                    imem_req_valid,
  input  logic                    imem_req_ready,
  output logic [ADDRESS_BITS-1:0] imem_req_addr,
  input  logic                    imem_rsp_valid,
  input  logic [INST_W-1:0]       imem_rsp_data,
  output logic                    inst_valid,
  input  logic                    inst_ready,
  output logic [ADDRESS_BITS-1:0] inst_PC,
  output logic [INST_W-1:0]       instruction,
  input  logic                    redirect_valid,
  input  logic [ADDRESS_BITS-1:0] redirect_target,
  input  logic                    scan
);
  localparam logic [ADDRESS_BITS-1:0] ALIGN = {{(ADDRESS_BITS-2){1'b1}}, 2'b00};

  fetch_state_e              state;
  logic [ADDRESS_BITS-1:0]   fetch_pc;
  logic [1:0]                outstanding;
  logic [1:0]                drop_count;
  logic [1:0]                drop_new;
  logic [1:0]                inst_count;
  logic [1:0]                pc_count;
  logic [ADDRESS_BITS-1:0]   pc_head;
  logic [ADDRESS_BITS+INST_W-1:0] inst_head;
  logic                      accept;
  logic                      rsp_live;
  logic                      rsp_keep;
  logic                      deq;
  logic [2:0]                unused_bits;

  // The scan trace is a simulation hook only; nothing in hardware consumes it.
  assign unused_bits = {scan ^ CORE[0], pc_count};

  assign imem_req_valid = (state == RUN) & ~redirect_valid &
                          (({1'b0, outstanding} + {1'b0, inst_count}) < 3'd2);
  assign imem_req_addr  = fetch_pc;
  assign accept         = imem_req_valid & imem_req_ready;
  assign rsp_live       = imem_rsp_valid & (outstanding != 2'd0);
  // Responses in the redirect cycle or while draining belong to the old path.
  assign rsp_keep       = rsp_live & ~redirect_valid & (state != DRAIN);
  assign drop_new       = outstanding - {1'b0, rsp_live};
  assign inst_valid     = (inst_count != 2'd0);
  assign deq            = inst_valid & inst_ready;
  assign {inst_PC, instruction} = inst_head;

  fifo2_sync #(.W(ADDRESS_BITS)) u_pc_q (
    .clock     (clock),
    .reset     (reset),
    .flush     (redirect_valid),
    .push      (accept),
    .push_data (fetch_pc),
    .pop       (rsp_keep),
    .head      (pc_head),
    .count     (pc_count)
  );

  fifo2_sync #(.W(ADDRESS_BITS + INST_W)) u_inst_q (
    .clock     (clock),
    .reset     (reset),
    .flush     (redirect_valid),
    .push      (rsp_keep),
    .push_data ({pc_head, imem_rsp_data}),
    .pop       (deq),
    .head      (inst_head),
    .count     (inst_count)
  );

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state       <= IDLE;
      fetch_pc    <= RESET_PC;
      outstanding <= 2'd0;
      drop_count  <= 2'd0;
    end else begin
      outstanding <= outstanding + {1'b0, accept} - {1'b0, rsp_live};
      if (redirect_valid)  fetch_pc <= redirect_target & ALIGN;
      else if (accept)     fetch_pc <= fetch_pc + ADDRESS_BITS'(4);
      case (state)
        IDLE: state <= RUN;
        RUN: begin
          if (redirect_valid) begin
            drop_count <= drop_new;
            state      <= (drop_new != 2'd0) ? DRAIN : RUN;
          end
        end
        DRAIN: begin
          // A redirect here only moves fetch_pc; old responses still drain.
          if (rsp_live) begin
            drop_count <= drop_count - 2'd1;
            if (drop_count == 2'd1) state <= RUN;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_fetch_buffer_unit.sv
// Randomized bench: in-order memory model plus program-order PC/word model.
module tb_fetch_buffer_unit;
  logic        clock = 1'b0;
  logic        reset;
  logic        imem_req_valid;
  logic        imem_req_ready;
  logic [31:0] imem_req_addr;
  logic        imem_rsp_valid;
  logic [31:0] imem_rsp_data;
  logic        inst_valid;
  logic        inst_ready;
  logic [31:0] inst_PC;
  logic [31:0] instruction;
  logic        redirect_valid;
  logic [31:0] redirect_target;
  logic        scan;

  fetch_buffer_unit #(.CORE(0), .ADDRESS_BITS(32), .RESET_PC(32'h0)) dut (
    .clock(clock), .reset(reset),
    .imem_req_valid(imem_req_valid), .imem_req_ready(imem_req_ready),
    .imem_req_addr(imem_req_addr), .imem_rsp_valid(imem_rsp_valid),
    .imem_rsp_data(imem_rsp_data), .inst_valid(inst_valid),
    .inst_ready(inst_ready), .inst_PC(inst_PC), .instruction(instruction),
    .redirect_valid(redirect_valid), .redirect_target(redirect_target),
    .scan(scan)
  );

  always #5 clock = ~clock;

  typedef struct { logic [31:0] addr; int due; } mreq_t;
  mreq_t       mq[$];
  int          cyc, last_due, lat;
  int          n_vec, n_err, n_acc, n_cons;
  logic [31:0] exp_pc, exp_fetch;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    if (a == 32'h0) return 32'hfe010113;
    return (a * 32'h9e3779b1) ^ 32'h00c0ffee;
  endfunction

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  task automatic do_reset();
    @(negedge clock);
    reset = 1'b0;
    imem_req_ready = 1'b0; inst_ready = 1'b0; redirect_valid = 1'b0;
    redirect_target = '0; imem_rsp_valid = 1'b0; imem_rsp_data = '0;
    mq.delete();
    exp_pc = 32'h0; exp_fetch = 32'h0; n_acc = 0; last_due = 0;
    #1;
    chk("rst_req_valid", {31'b0, imem_req_valid}, 32'd0);
    chk("rst_inst_valid", {31'b0, inst_valid}, 32'd0);
    chk("rst_inst_pc", inst_PC, 32'h0);
    chk("rst_instruction", instruction, 32'h0);
    chk("rst_req_addr", imem_req_addr, 32'h0);
    repeat (2) @(posedge clock);
    @(negedge clock);
    reset = 1'b1;
    #1;
    chk("idle_no_req", {31'b0, imem_req_valid}, 32'd0);
    cyc++;
  endtask

  task automatic cycle(input bit rdy, input bit irdy, input bit redir, input logic [31:0] tgt);
    int due;
    @(negedge clock);
    imem_req_ready = rdy; inst_ready = irdy;
    redirect_valid = redir; redirect_target = tgt;
    if (mq.size() > 0 && mq[0].due <= cyc) begin
      imem_rsp_valid = 1'b1;
      imem_rsp_data  = mem_word(mq[0].addr);
      void'(mq.pop_front());
    end else begin
      imem_rsp_valid = 1'b0;
      imem_rsp_data  = $urandom;
    end
    #1;
    if (inst_valid && inst_ready) begin
      chk("inst_pc", inst_PC, exp_pc);
      chk("inst_word", instruction, mem_word(exp_pc));
      exp_pc += 32'd4;
      n_cons++;
    end
    if (redir) chk("req_during_redirect", {31'b0, imem_req_valid}, 32'd0);
    if (imem_req_valid && imem_req_ready) begin
      chk("req_addr", imem_req_addr, exp_fetch);
      exp_fetch += 32'd4;
      n_acc++;
      due = (cyc + lat > last_due) ? cyc + lat : last_due + 1;
      last_due = due;
      mq.push_back('{addr: imem_req_addr, due: due});
    end
    if (redir) begin
      exp_pc    = tgt & 32'hffff_fffc;
      exp_fetch = tgt & 32'hffff_fffc;
    end
    cyc++;
  endtask

  initial begin
    int c0;
    n_vec = 0; n_err = 0; n_cons = 0; cyc = 0; lat = 1; scan = 1'b0;
    reset = 1'b0; imem_req_ready = 1'b0; inst_ready = 1'b0; redirect_valid = 1'b0;
    redirect_target = '0; imem_rsp_valid = 1'b0; imem_rsp_data = '0;

    // Back-to-back sequential fetch with one-cycle memory.
    do_reset();
    cycle(1, 1, 0, 0);
    chk("first_req_addr", imem_req_addr, 32'h0);
    repeat (10) cycle(1, 1, 0, 0);
    chk("seq_consumed", (n_cons >= 3) ? 32'd1 : 32'd0, 32'd1);

    // Decode stalls: FIFO fills and fetch stops after two requests.
    do_reset();
    repeat (8) cycle(1, 0, 0, 0);
    chk("full_no_req", {31'b0, imem_req_valid}, 32'd0);
    chk("full_inst_valid", {31'b0, inst_valid}, 32'd1);
    chk("full_req_count", n_acc, 32'd2);
    // Reset while the FIFO is full, then fetch restarts at RESET_PC.
    do_reset();
    cycle(1, 1, 0, 0);
    chk("post_rst_req", {31'b0, imem_req_valid}, 32'd1);
    chk("post_rst_addr", imem_req_addr, 32'h0);
    repeat (6) cycle(1, 1, 0, 0);

    // Redirect with two requests in flight: the next two responses are dropped.
    do_reset();
    lat = 3;
    cycle(1, 1, 0, 0);
    cycle(1, 1, 0, 0);
    cycle(1, 1, 1, 32'h0000_0103);
    cycle(1, 1, 0, 0);
    chk("drain_no_req", {31'b0, imem_req_valid}, 32'd0);
    c0 = n_cons;
    repeat (12) cycle(1, 1, 0, 0);
    chk("drain_resumed", (n_cons > c0) ? 32'd1 : 32'd0, 32'd1);

    // Redirect coincident with the only outstanding response.
    do_reset();
    lat = 1;
    cycle(1, 1, 0, 0);
    cycle(1, 1, 1, 32'h0000_0100);
    cycle(1, 1, 0, 0);
    chk("coinc_req", {31'b0, imem_req_valid}, 32'd1);
    chk("coinc_addr", imem_req_addr, 32'h0000_0100);
    repeat (6) cycle(1, 1, 0, 0);

    // Address wrap at the top of the address space.
    cycle(1, 1, 1, 32'hffff_fff8);
    repeat (10) cycle(1, 1, 0, 0);
    chk("wrap_fetch", exp_fetch < 32'h40 ? 32'd1 : 32'd0, 32'd1);

    // Randomized traffic.
    c0 = n_cons;
    for (int i = 0; i < 4000; i++) begin
      if (i % 500 == 0) lat = $urandom_range(1, 4);
      if ($urandom_range(0, 999) == 0) do_reset();
      cycle($urandom_range(0, 3) != 0, $urandom_range(0, 9) < 7,
            $urandom_range(0, 39) == 0, $urandom);
    end
    chk("random_progress", (n_cons - c0 > 300) ? 32'd1 : 32'd0, 32'd1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
